// File: rtl/pkt_arb_pkg.sv
// pkt_arb_pkg: shared types, header field positions and payload flit formatting for pkt_arb
package pkt_arb_pkg;
  typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;
  localparam int DEST_MSB = 63;
  localparam int DEST_LSB = 56;
  function automatic logic [63:0] body_flit(input logic [7:0] idx, input logic [31:0] k);
    return {idx, 24'h0, k};
  endfunction
endpackage

// File: rtl/pkt_arb_rr.sv
// rr_arb: round-robin grant over req, pointer advances past the winner when advance is high
//   clk, rst      clock and synchronous active-high reset
//   req, advance  request vector; advance commits the current grant
//   gnt, gnt_idx  one-hot grant and its index (combinational from pointer and req)
module rr_arb #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 advance,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx
);
  localparam int IW = $clog2(N);
  logic [IW-1:0] ptr;
  // walk offsets from far to near so the closest requester after ptr wins last
  always_comb begin
    gnt = '0;
    gnt_idx = '0;
    for (int o = N - 1; o >= 0; o--) begin
      if (req[(int'(ptr) + o) % N]) begin
        gnt = '0;
        gnt[(int'(ptr) + o) % N] = 1'b1;
        gnt_idx = IW'((int'(ptr) + o) % N);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) ptr <= '0;
    else if (advance && |req) ptr <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
  end
endmodule

// File: rtl/pkt_arb.sv
// pkt_arb: round-robin packet arbiter emitting header + payload flits toward a router port
//   clk, rst            clock and synchronous active-high reset
//   go, dest, len       per-requester launch, header flit and payload length
//   busy, done          per-requester pending/active flag and completion pulse
//   q, q_valid, q_sof   flit stream; q_bp high stalls acceptance
//   pkt_cnt             per-requester completed packet counters (only with PKT_ARB_STATS_EN)
module pkt_arb
  import pkt_arb_pkg::*;
#(
  parameter int NumPorts = 4,
  parameter int LenW     = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NumPorts-1:0]            go,
  input  logic [NumPorts-1:0][63:0]      dest,
  input  logic [NumPorts-1:0][LenW-1:0]  len,
  output logic [NumPorts-1:0]            busy,
  output logic [NumPorts-1:0]            done,
  output logic [63:0]                    q,
  output logic                           q_valid,
  output logic                           q_sof,
  input  logic                           q_bp
`ifdef PKT_ARB_STATS_EN
  ,
  output logic [NumPorts-1:0][31:0]      pkt_cnt
`endif
);
  localparam int IW = $clog2(NumPorts);
  state_t state, state_n;
  logic [NumPorts-1:0][63:0] dest_q;
  logic [NumPorts-1:0][LenW-1:0] len_q;
  logic [NumPorts-1:0] gnt, gnt_q, done_n;
  logic [IW-1:0] gnt_idx, g;
  logic [LenW-1:0] len_a, k, k_n;
  logic [63:0] q_n;
  logic q_valid_n, q_sof_n, fin, acc, last, advance;
  assign acc = q_valid & ~q_bp;
  assign last = k == len_a - 1'b1;
  assign advance = state == IDLE && |busy;
  rr_arb #(.N(NumPorts)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (busy),
    .advance (advance),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state == IDLE ? (|busy ? HEAD : IDLE)
            : state == HEAD ? (acc ? (len_a == '0 ? IDLE : BODY) : HEAD)
            : (acc && last ? IDLE : BODY);
  end
  // output register is filled on HEAD entry and refilled only when its flit is accepted
  always_comb begin
    q_n = q;
    q_valid_n = q_valid;
    q_sof_n = q_sof;
    k_n = k;
    fin = 1'b0;
    if (state == HEAD && !q_valid) begin
      q_n = dest_q[g];
      q_valid_n = 1'b1;
      q_sof_n = 1'b1;
    end else if (state == HEAD && acc && len_a == '0) begin
      q_valid_n = 1'b0;
      q_sof_n = 1'b0;
      fin = 1'b1;
    end else if (state == HEAD && acc) begin
      q_n = body_flit(8'(g), 32'h0);
      q_sof_n = 1'b0;
      k_n = '0;
    end else if (state == BODY && acc && last) begin
      q_valid_n = 1'b0;
      fin = 1'b1;
    end else if (state == BODY && acc) begin
      k_n = k + 1'b1;
      q_n = body_flit(8'(g), 32'(k + 1'b1));
    end
    done_n = fin ? gnt_q : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
      q_valid <= 1'b0;
      q_sof <= 1'b0;
      k <= '0;
      done <= '0;
      busy <= '0;
      g <= '0;
      gnt_q <= '0;
      len_a <= '0;
    end else begin
      q <= q_n;
      q_valid <= q_valid_n;
      q_sof <= q_sof_n;
      k <= k_n;
      done <= done_n;
      if (advance) begin
        g <= gnt_idx;
        gnt_q <= gnt;
        len_a <= len_q[gnt_idx];
      end
      for (int i = 0; i < NumPorts; i++) begin
        if (done_n[i]) busy[i] <= 1'b0;
        else if (go[i] && !busy[i]) busy[i] <= 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < NumPorts; i++) begin
      if (go[i] && !busy[i]) begin
        dest_q[i] <= dest[i];
        len_q[i] <= len[i];
      end
    end
  end
`ifdef PKT_ARB_STATS_EN
  always_ff @(posedge clk) begin
    for (int i = 0; i < NumPorts; i++) begin
      if (rst) pkt_cnt[i] <= '0;
      else if (done_n[i]) pkt_cnt[i] <= pkt_cnt[i] + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_pkt_arb.sv
// tb_pkt_arb: directed scoreboard bench for pkt_arb
module tb_pkt_arb;
  localparam int NP = 4;
  localparam int LW = 16;
  localparam int HDR_GAP = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NP-1:0] go = '0;
  logic [NP-1:0][63:0] dest = '0;
  logic [NP-1:0][LW-1:0] len = '0;
  logic q_bp = 1'b0;
  logic [NP-1:0] busy, done;
  logic [63:0] q;
  logic q_valid, q_sof;
`ifdef PKT_ARB_STATS_EN
  logic [NP-1:0][31:0] pkt_cnt;
`endif
  typedef struct packed {
    logic          sof;
    logic [63:0]   q;
    logic [NP-1:0] dm;
  } exp_t;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_done = 0;
  int ndone = 0;
  int exp_cnt[NP];
  bit gap_on = 1'b0;
  bit stall = 1'b0;
  logic [65:0] held;
  always #5 clk = ~clk;
  pkt_arb #(.NumPorts(NP), .LenW(LW)) dut (
    .clk     (clk),
    .rst     (rst),
    .go      (go),
    .dest    (dest),
    .len     (len),
    .busy    (busy),
    .done    (done),
    .q       (q),
    .q_valid (q_valid),
    .q_sof   (q_sof),
    .q_bp    (q_bp)
`ifdef PKT_ARB_STATS_EN
    ,
    .pkt_cnt (pkt_cnt)
`endif
  );
  function automatic logic [63:0] bflit(int p, int k);
    logic [7:0] pi = 8'(p);
    logic [31:0] ki = 32'(k);
    return {pi, 24'h0, ki};
  endfunction
  task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic push_pkt(int p, logic [63:0] d, int n);
    logic [NP-1:0] m = NP'(1) << p;
    sb.push_back({1'b1, d, n == 0 ? m : NP'(0)});
    for (int k = 0; k < n; k++) sb.push_back({1'b0, bflit(p, k), k == n - 1 ? m : NP'(0)});
  endtask
  task automatic tick();
    logic [NP-1:0] dm = '0;
    exp_t e;
    if (stall) chk("hold", {q_valid, q_sof, q}, held);
    if (!rst && q_valid && !q_bp) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL extra_flit got %h expected none", q);
      end else begin
        e = sb.pop_front();
        chk("flit", {q_sof, q}, {e.sof, e.q});
        dm = e.dm;
        if (e.sof && gap_on && ndone > 0) chk("gap", cyc - last_done, HDR_GAP);
      end
    end
    stall = !rst && q_valid && q_bp;
    held = {q_valid, q_sof, q};
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (rst) begin
      sb.delete();
      foreach (exp_cnt[i]) exp_cnt[i] = 0;
      dm = '0;
    end
    chk("done", done, dm);
    if (|dm) begin
      chk("busy_clr", busy & dm, 0);
      last_done = cyc;
      ndone++;
      for (int i = 0; i < NP; i++) exp_cnt[i] += int'(dm[i]);
    end
  endtask
  task automatic drain(int maxc);
    int n = 0;
    while (sb.size() > 0 && n < maxc) begin
      tick();
      n++;
    end
    chk("drain", sb.size(), 0);
  endtask
  task automatic chk_stats();
`ifdef PKT_ARB_STATS_EN
    for (int i = 0; i < NP; i++) chk("pkt_cnt", pkt_cnt[i], exp_cnt[i]);
`endif
  endtask
  initial begin
    foreach (exp_cnt[i]) exp_cnt[i] = 0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_q", q, 0);
    chk("rst_valid", {q_valid, q_sof}, 0);
    chk("rst_busy", busy, 0);
    dest[0] = {8'h01, 56'h4};
    len[0] = 3;
    go[0] = 1'b1;
    push_pkt(0, dest[0], 3);
    tick();
    go = '0;
    chk("busy_set", busy, 4'b0001);
    chk("lat_t1", q_valid, 0);
    tick();
    chk("lat_t2", q_valid, 0);
    tick();
    chk("hdr_lat", {q_valid, q_sof}, 2'b11);
    drain(20);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NP; i++) begin
      dest[i] = {8'(16 + i), 56'(i)};
      len[i] = 500;
      push_pkt(i, dest[i], 500);
    end
    go = '1;
    gap_on = 1'b1;
    ndone = 0;
    tick();
    go = '0;
    drain(3000);
    gap_on = 1'b0;
    chk("four_done", ndone, 4);
    chk_stats();
    dest[1] = 64'hA1A5_0000_1234_5678;
    len[1] = 4;
    go[1] = 1'b1;
    push_pkt(1, dest[1], 4);
    tick();
    dest[1] = '1;
    len[1] = 9;
    tick();
    go = '0;
    for (int n = 0; n < 100 && sb.size() > 0; n++) begin
      q_bp = ~q_bp;
      tick();
    end
    q_bp = 1'b0;
    chk("bp_drain", sb.size(), 0);
    tick();
    dest[2] = {8'h22, 56'h2};
    len[2] = 0;
    go[2] = 1'b1;
    push_pkt(2, dest[2], 0);
    tick();
    go = '0;
    drain(20);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    dest[0] = {8'h05, 56'h0};
    len[0] = 100;
    go[0] = 1'b1;
    push_pkt(0, dest[0], 100);
    tick();
    go = '0;
    for (int n = 0; n < 200 && !(q_valid && q === bflit(0, 10)); n++) tick();
    chk("reach10", {q_valid, q}, {1'b1, bflit(0, 10)});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rmid_valid", {q_valid, q_sof}, 0);
    chk("rmid_busy", busy, 0);
    chk("rmid_q", q, 0);
    dest[1] = {8'h11, 56'h1};
    len[1] = 2;
    go[1] = 1'b1;
    push_pkt(1, dest[1], 2);
    tick();
    go = '0;
    drain(20);
    repeat (3) tick();
    dest[2] = {8'h22, 56'h7};
    len[2] = 1;
    go[2] = 1'b1;
    push_pkt(2, dest[2], 1);
    tick();
    go = '0;
    drain(20);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    dest[1] = {8'h11, 56'h9};
    len[1] = 1;
    dest[3] = {8'h33, 56'h3};
    len[3] = 1;
    go = 4'b1010;
    push_pkt(1, dest[1], 1);
    push_pkt(3, dest[3], 1);
    tick();
    go = '0;
    drain(40);
    repeat (3) tick();
    chk_stats();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pkt_arb.md
PKT_ARB -- requirements
Module: pkt_arb

Interface
REQ-001 Parameter NumPorts, default 4: number of requesters; legal range 2..8.
REQ-002 Parameter LenW, default 16: width of each payload length field.
REQ-003 CLK  input  1: single clock; all state updates on its rising edge.
REQ-004 RST  input  1: reset, synchronous and active-high.
REQ-005 GO  input  [NumPorts-1:0]: per-requester launch request, sampled each cycle.
REQ-006 DEST  input  [NumPorts-1:0][63:0]: header flit per requester; bits 63:56 are the router destination, bits 55:0 are opaque. Captured on the accepted GO.
REQ-007 LEN  input  [NumPorts-1:0][LenW-1:0]: payload flit count per requester, captured on the accepted GO.
REQ-008 BUSY  output  [NumPorts-1:0]: requester has a pending or active packet.
REQ-009 DONE  output  [NumPorts-1:0]: one-cycle completion pulse per requester.
REQ-010 Q  output  64: flit toward the router input.
REQ-011 Q_VALID  output  1: Q holds a valid flit.
REQ-012 Q_SOF  output  1: marks the header flit.
REQ-013 Q_BP  input  1: downstream backpressure; the flit is not accepted while high.

Function
REQ-014 GO[i] with BUSY[i]=0 latches DEST[i] and LEN[i] and sets BUSY[i] on the next edge. GO[i] with BUSY[i]=1 is ignored.
REQ-015 FSM states: IDLE, HEAD, BODY.
- IDLE: if any requester is pending, grant one round-robin, load its length, go to HEAD. Otherwise stay in IDLE.
REQ-016 Round-robin order: the search starts at the index after the last grant and wraps from NumPorts-1 to 0. After reset the search starts at index 0.
REQ-017 Latency: GO accepted at edge t, granted at edge t+1, header visible with Q_VALID=1 after edge t+2.
REQ-018 HEAD: Q=latched DEST, Q_SOF=1, Q_VALID=1.
- On acceptance (Q_VALID and not Q_BP), go to BODY, or to IDLE when LEN=0.
REQ-019 BODY: flit k (k=0..LEN-1) is {grant index zero-extended to 8 bits, 24'h0, k as 32 bits}, with Q_SOF=0.
- k advances only on acceptance. Go to IDLE after flit LEN-1 is accepted.
REQ-020 While Q_BP=1, Q, Q_VALID and Q_SOF hold stable. The FSM never drops Q_VALID until its flit is accepted.
REQ-021 On the final accepted flit: DONE[g]=1 and BUSY[g]=0 in the next cycle.
- Exactly one IDLE bubble cycle separates consecutive packets.
- A new GO[g] is accepted from the cycle BUSY[g] reads 0.
REQ-022 Requests arriving during an active packet remain pending. They do not affect the current grant.
REQ-023 At most one DONE bit is high in any cycle.
REQ-024 Q_VALID=0 in IDLE. The value of Q is don't-care when Q_VALID=0.

Reset
REQ-025 RST=1 at an edge clears the following on that edge: FSM to IDLE, Q_VALID, Q_SOF, BUSY, DONE, the flit counter, and the pointer to 0. This applies even mid-packet.
REQ-026 A packet interrupted by reset produces no DONE pulse, and its remaining flits are never emitted.
REQ-027 Q resets to 0. No output is X after the first reset edge.

Configuration
REQ-028 Macro PKT_ARB_STATS_EN:
- Defined: adds output PKT_CNT [NumPorts-1:0][31:0], a per-requester count of completed packets. It increments with each DONE pulse, wraps at 2^32, and is cleared by RST.
- Undefined: the port and counters are absent. All other behaviour is identical.

Structure
REQ-029 Shared package pkt_arb_pkg holds:
- the state enum (IDLE, HEAD, BODY);
- header field constants (DEST_MSB=63, DEST_LSB=56);
- the payload-flit formatting function.
REQ-030 Sub-module rr_arb: parameter N; inputs req [N-1:0] and advance; outputs gnt (one-hot) and gnt_idx. It owns the round-robin pointer.

Verification
REQ-031 Single request: GO[0] with DEST={8'h01,56'h4}, LEN=3, Q_BP=0.
- Expect header at cycle +2 with Q_SOF=1, then payload words 0x0,0x1,0x2.
- Expect DONE[0] one cycle after the last payload word.
REQ-032 Four simultaneous GO, LEN=500 each.
- Expect grant order 0,1,2,3, 501 flits each, one bubble between packets.
- Expect each DONE once; PKT_CNT={1,1,1,1} when the macro is defined.
REQ-033 Backpressure: LEN=4, Q_BP toggling every cycle.
- Q and Q_SOF stay stable across stalls; the sequence is still header + 0..3.
REQ-034 LEN=0 on port 2:
- A single header flit with Q_SOF=1, then DONE[2]; no BODY cycle.
REQ-035 Reset mid-packet: RST raised at payload flit 10 of LEN=100.
- Q_VALID=0 and BUSY=0 the next cycle; no DONE.
- The next GO[1] is granted before GO[0] is served again, because the pointer restarts at 0 and port 0 did not re-request.
